immed_gen_pipe: RTL and testbench

// - Registered, handshaked immediate generator for the decode stage.
// - Accepts one 32-bit RV instruction per cycle plus a sideband tag (e.g. PC).
// - Emits the sign-extended XLEN immediate, its format class and an illegal-opcode flag.
// - Sits between fetch and decode. Supports XLEN 32/64 and an optional skid buffer

---
 rtl/immed_gen_if.sv | 29 ++
 rtl/immed_gen_pipe.sv | 161 ++++++++++++++++
 tb/tb_immed_gen_pipe.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/immed_gen_if.sv
// Handshake bundle between fetch, the immediate generator and decode.
// The master side drives instructions and out_ready. The slave side is the generator.
interface immed_gen_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic [TAG_W-1:0] out_tag;
  logic [XLEN-1:0]  out_immed;
  logic [2:0]       out_imm_type;
  logic             out_illegal;

  modport master (
    output flush, in_valid, in_inst, in_tag, out_ready,
    input  in_ready, out_valid, out_inst, out_tag, out_immed, out_imm_type, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_inst, in_tag, out_ready,
    output in_ready, out_valid, out_inst, out_tag, out_immed, out_imm_type, out_illegal
  );
endinterface

// File: rtl/immed_gen_pipe.sv
// Registered, handshaked RV immediate generator with an optional 2-entry skid buffer.
// Defining IMMED_GEN_ZICSR_EN decodes the CSR*I uimm field as immediate type Z.
module immed_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter bit SKID  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  immed_gen_if.slave bus
);

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;
`ifdef IMMED_GEN_ZICSR_EN
  localparam logic [2:0] IMM_Z    = 3'd6;
`endif

  typedef struct packed {
    logic [31:0]      inst;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  immed;
    logic [2:0]       imm_type;
    logic             illegal;
  } beat_t;

  logic [31:0]     inst;
  logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] dec_immed;
  logic [2:0]      dec_type;
  logic            dec_illegal;

  assign inst  = bus.in_inst;
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  // Opcode includes inst[1:0], so compressed encodings fall through to illegal.
  always_comb begin
    dec_immed   = '0;
    dec_type    = IMM_NONE;
    dec_illegal = 1'b0;
    case (inst[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
        dec_type  = IMM_I;
        dec_immed = XLEN'($signed(imm_i));
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin
          dec_type  = IMM_I;
          dec_immed = XLEN'($signed(imm_i));
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        dec_type  = IMM_S;
        dec_immed = XLEN'($signed(imm_s));
      end
      OPC_BRANCH: begin
        dec_type  = IMM_B;
        dec_immed = XLEN'($signed(imm_b));
      end
      OPC_JAL: begin
        dec_type  = IMM_J;
        dec_immed = XLEN'($signed(imm_j));
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_type  = IMM_U;
        dec_immed = XLEN'($signed(imm_u));
      end
      OPC_OP, OPC_MISC_MEM: begin
        dec_type = IMM_NONE;
      end
      OPC_OP_32: begin
        dec_illegal = (XLEN != 64);
      end
      OPC_SYSTEM: begin
`ifdef IMMED_GEN_ZICSR_EN
        if (inst[14]) begin
          dec_type  = IMM_Z;
          dec_immed = XLEN'(inst[19:15]);
        end
`else
        dec_type = IMM_NONE;
`endif
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  beat_t in_beat, main_q, skid_q;
  logic  main_valid, skid_valid;
  logic  accept, drain, main_load, ready_raw;

  assign in_beat = '{inst: bus.in_inst, tag: bus.in_tag, immed: dec_immed,
                     imm_type: dec_type, illegal: dec_illegal};

  // With the skid buffer, in_ready depends only on registered state.
  assign ready_raw    = SKID ? ~skid_valid : (bus.out_ready | ~main_valid);
  assign bus.in_ready = ready_raw & ~rst;
  assign accept       = bus.in_valid & bus.in_ready;
  assign drain        = main_valid & bus.out_ready;
  assign main_load    = drain | ~main_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (bus.flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_load) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q     <= in_beat;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= in_beat;
      skid_valid <= 1'b1;
    end
  end

  assign bus.out_valid    = main_valid;
  assign bus.out_inst     = main_q.inst;
  assign bus.out_tag      = main_q.tag;
  assign bus.out_immed    = main_q.immed;
  assign bus.out_imm_type = main_q.imm_type;
  assign bus.out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_immed_gen_pipe.sv
// Bench for immed_gen_pipe: XLEN=32/SKID=1 and XLEN=64/SKID=0 instances, table vectors,
// queue scoreboards and hand-written backpressure, flush and reset sequences.
module tb_immed_gen_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  immed_gen_if #(.XLEN(32), .TAG_W(32)) a();
  immed_gen_if #(.XLEN(64), .TAG_W(32)) b();

  immed_gen_pipe #(.XLEN(32), .TAG_W(32), .SKID(1'b1)) u_dut32 (.clk(clk), .rst(rst), .bus(a));
  immed_gen_pipe #(.XLEN(64), .TAG_W(32), .SKID(1'b0)) u_dut64 (.clk(clk), .rst(rst), .bus(b));

  typedef struct {
    logic [31:0] inst;
    logic [63:0] imm;
    logic [2:0]  ty;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] tag;
    logic [63:0] imm;
    logic [2:0]  ty;
    logic        ill;
  } exp_t;

  localparam int N32 = 17;
  localparam int N64 = 8;

  vec_t v32 [N32];
  vec_t v64 [N64];
  exp_t q32 [$];
  exp_t q64 [$];
  exp_t pend32, pend64;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) q32.delete();
    else begin
      if (a.out_valid && a.out_ready) begin
        if (q32.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb32_extra: unexpected output inst %h", a.out_inst);
        end else begin
          e = q32.pop_front();
          check("sb32", {a.out_inst, a.out_tag, 32'h0, a.out_immed, a.out_imm_type, a.out_illegal},
                {e.inst, e.tag, e.imm, e.ty, e.ill});
        end
      end
      if (a.flush) q32.delete();
      if (a.in_valid && a.in_ready && !a.flush) q32.push_back(pend32);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) q64.delete();
    else begin
      if (b.out_valid && b.out_ready) begin
        if (q64.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb64_extra: unexpected output inst %h", b.out_inst);
        end else begin
          e = q64.pop_front();
          check("sb64", {b.out_inst, b.out_tag, b.out_immed, b.out_imm_type, b.out_illegal},
                {e.inst, e.tag, e.imm, e.ty, e.ill});
        end
      end
      if (b.flush) q64.delete();
      if (b.in_valid && b.in_ready && !b.flush) q64.push_back(pend64);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sel64, input vec_t v, input logic [31:0] tag);
    bit acc = 1'b0;
    if (sel64) begin
      b.in_valid = 1'b1; b.in_inst = v.inst; b.in_tag = tag;
      pend64 = '{v.inst, tag, v.imm, v.ty, v.ill};
    end else begin
      a.in_valid = 1'b1; a.in_inst = v.inst; a.in_tag = tag;
      pend32 = '{v.inst, tag, v.imm, v.ty, v.ill};
    end
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = sel64 ? (b.in_ready === 1'b1) : (a.in_ready === 1'b1);
      tick();
    end
    a.in_valid = 1'b0;
    b.in_valid = 1'b0;
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: inst %h never accepted", v.inst);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && (q32.size() != 0 || q64.size() != 0); i++) tick();
    check({name, "_q32"}, q32.size(), 0);
    check({name, "_q64"}, q64.size(), 0);
  endtask

  initial begin
    int c0, k, gaps;
    bit acc;

    a.flush = 1'b0; a.in_valid = 1'b0; a.in_inst = '0; a.in_tag = '0; a.out_ready = 1'b0;
    b.flush = 1'b0; b.in_valid = 1'b0; b.in_inst = '0; b.in_tag = '0; b.out_ready = 1'b0;

    v32[0]  = '{32'hFFF00093, 64'hFFFFFFFF, 3'd1, 1'b0};
    v32[1]  = '{32'hFE000EE3, 64'hFFFFFFFC, 3'd3, 1'b0};
    v32[2]  = '{32'h123452B7, 64'h12345000, 3'd4, 1'b0};
    v32[3]  = '{32'h0000000B, 64'h0,        3'd0, 1'b1};
`ifdef IMMED_GEN_ZICSR_EN
    v32[4]  = '{32'h3001D073, 64'h3,        3'd6, 1'b0};
`else
    v32[4]  = '{32'h3001D073, 64'h0,        3'd0, 1'b0};
`endif
    v32[5]  = '{32'hFE112E23, 64'hFFFFFFFC, 3'd2, 1'b0};
    v32[6]  = '{32'h0080006F, 64'h8,        3'd5, 1'b0};
    v32[7]  = '{32'hFF9FF06F, 64'hFFFFFFF8, 3'd5, 1'b0};
    v32[8]  = '{32'h7FF12083, 64'h7FF,      3'd1, 1'b0};
    v32[9]  = '{32'h003100B3, 64'h0,        3'd0, 1'b0};
    v32[10] = '{32'hFFFFF117, 64'hFFFFF000, 3'd4, 1'b0};
    v32[11] = '{32'h0010009B, 64'h0,        3'd0, 1'b1};
    v32[12] = '{32'h00000073, 64'h0,        3'd0, 1'b0};
    v32[13] = '{32'h0FF0000F, 64'h0,        3'd0, 1'b0};
    v32[14] = '{32'h00008067, 64'h0,        3'd1, 1'b0};
    v32[15] = '{32'h00000001, 64'h0,        3'd0, 1'b1};
    v32[16] = '{32'h30002573, 64'h0,        3'd0, 1'b0};

    v64[0] = '{32'h800002B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
    v64[1] = '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    v64[2] = '{32'h0010009B, 64'h1,                3'd1, 1'b0};
    v64[3] = '{32'h003100BB, 64'h0,                3'd0, 1'b0};
    v64[4] = '{32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
    v64[5] = '{32'h0000000B, 64'h0,                3'd0, 1'b1};
    v64[6] = '{32'hFE112E23, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0};
    v64[7] = '{32'h123452B7, 64'h12345000,         3'd4, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid32", a.out_valid, 0);
    check("rst_in_ready32", a.in_ready, 0);
    check("rst_in_ready64", b.in_ready, 0);
    check("rst_payload32", {a.out_inst, a.out_tag, a.out_immed, a.out_imm_type, a.out_illegal}, 0);
    tick();
    rst = 1'b0;
    a.out_ready = 1'b1;
    b.out_ready = 1'b1;
    @(negedge clk);
    check("idle_in_ready32", a.in_ready, 1);
    tick();

    // One-cycle latency
    send(0, v32[0], 32'h100);
    @(negedge clk);
    check("lat_valid", a.out_valid, 1);
    check("lat_immed", a.out_immed, 32'hFFFFFFFF);
    check("lat_type", a.out_imm_type, 3'd1);
    tick();

    // Table stream, back to back
    c0 = cyc;
    for (int i = 0; i < N32; i++) send(0, v32[i], 32'h1000 + i);
    check("thru32_cycles", cyc - c0, N32);
    wait_drain("tbl32");

    // Backpressure: 4 beats, out_ready low for 3 cycles
    a.out_ready = 1'b0;
    k = 0;
    gaps = 0;
    for (int c = 0; c < 30 && (k < 4 || q32.size() != 0); c++) begin
      if (k < 4) begin
        a.in_valid = 1'b1; a.in_inst = v32[k + 1].inst; a.in_tag = 32'h200 + k;
        pend32 = '{v32[k + 1].inst, 32'h200 + k, v32[k + 1].imm, v32[k + 1].ty, v32[k + 1].ill};
      end else a.in_valid = 1'b0;
      if (c == 3) a.out_ready = 1'b1;
      @(negedge clk);
      if (c == 2) begin
        check("bp_in_ready_low", a.in_ready, 0);
        check("bp_accepts", k, 2);
        check("bp_hold", a.out_inst, v32[1].inst);
      end
      if (c >= 3 && c <= 6 && !a.out_valid) gaps++;
      acc = a.in_valid & a.in_ready;
      tick();
      if (acc) k++;
    end
    a.in_valid = 1'b0;
    check("bp_gaps", gaps, 0);
    check("bp_all_sent", k, 4);
    wait_drain("bp");

    // Flush with main+skid full and in_valid high
    a.out_ready = 1'b0;
    send(0, v32[2], 32'h300);
    send(0, v32[3], 32'h301);
    a.in_valid = 1'b1; a.in_inst = v32[4].inst; a.in_tag = 32'h302;
    pend32 = '{v32[4].inst, 32'h302, v32[4].imm, v32[4].ty, v32[4].ill};
    a.flush = 1'b1;
    @(negedge clk);
    tick();
    a.flush = 1'b0;
    a.in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", a.out_valid, 0);
    check("flush_in_ready", a.in_ready, 1);
    tick();
    a.out_ready = 1'b1;
    repeat (4) tick();
    wait_drain("flush1");

    // Flush while draining and accepting: drain delivered, accepted beat dropped
    send(0, v32[5], 32'h400);
    a.in_valid = 1'b1; a.in_inst = v32[6].inst; a.in_tag = 32'h401;
    pend32 = '{v32[6].inst, 32'h401, v32[6].imm, v32[6].ty, v32[6].ill};
    a.flush = 1'b1;
    @(negedge clk);
    check("flush_drain_valid", a.out_valid, 1);
    tick();
    a.flush = 1'b0;
    a.in_valid = 1'b0;
    @(negedge clk);
    check("flush2_out_valid", a.out_valid, 0);
    tick();
    repeat (3) tick();
    wait_drain("flush2");

    // Async reset mid-stream
    a.out_ready = 1'b0;
    send(0, v32[7], 32'h500);
    send(0, v32[8], 32'h501);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", a.out_valid, 0);
    check("arst_in_ready", a.in_ready, 0);
    check("arst_immed", a.out_immed, 0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    a.out_ready = 1'b1;
    send(0, v32[0], 32'h600);
    send(0, v32[2], 32'h601);
    wait_drain("rst");

    // XLEN=64, SKID=0
    b.out_ready = 1'b0;
    send(1, v64[0], 32'h700);
    @(negedge clk);
    check("s0_in_ready_blocked", b.in_ready, 0);
    tick();
    b.out_ready = 1'b1;
    #1;
    check("s0_in_ready_comb", b.in_ready, 1);
    c0 = cyc;
    for (int i = 0; i < N64; i++) send(1, v64[i], 32'h800 + i);
    check("thru64_cycles", cyc - c0, N64);
    wait_drain("tbl64");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
